// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Iterative restoring divider (DIV/DIVU) with annul, {rem, quo} out
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]   r_quo, w_quo_nxt;       // dividend in, quotient out
   logic [WIDTH-1:0]   r_rem, w_rem_nxt;
   logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
   logic               r_sign1, w_sign1_nxt;
   logic               r_sign2, w_sign2_nxt;
   logic               r_signed, w_signed_nxt;
   logic [2*WIDTH-1:0] w_result_nxt;
   logic               w_ready_nxt;

   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   // Shifted partial remainder can reach 2*divisor-1, so one extra bit is kept
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_dvs};
   assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = (r_signed && r_sign1) ? (~r_rem + 1'b1) : r_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= FREE;
         r_cnt    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dvs    <= '0;
         r_sign1  <= 1'b0;
         r_sign2  <= 1'b0;
         r_signed <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_quo    <= w_quo_nxt;
         r_rem    <= w_rem_nxt;
         r_dvs    <= w_dvs_nxt;
         r_sign1  <= w_sign1_nxt;
         r_sign2  <= w_sign2_nxt;
         r_signed <= w_signed_nxt;
         result_o <= w_result_nxt;
         ready_o  <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_quo_nxt    = r_quo;
      w_rem_nxt    = r_rem;
      w_dvs_nxt    = r_dvs;
      w_sign1_nxt  = r_sign1;
      w_sign2_nxt  = r_sign2;
      w_signed_nxt = r_signed;
      w_result_nxt = result_o;
      w_ready_nxt  = ready_o;

      unique case (r_state)
         FREE: begin
            w_result_nxt = '0;
            w_ready_nxt  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  w_state_nxt = BYZERO;
               end else begin
                  w_state_nxt  = ON;
                  w_cnt_nxt    = '0;
                  w_rem_nxt    = '0;
                  w_signed_nxt = signed_div_i;
                  w_sign1_nxt  = opdata1_i[WIDTH-1];
                  w_sign2_nxt  = opdata2_i[WIDTH-1];
                  w_quo_nxt    = (signed_div_i && opdata1_i[WIDTH-1]) ?
                                 (~opdata1_i + 1'b1) : opdata1_i;
                  w_dvs_nxt    = (signed_div_i && opdata2_i[WIDTH-1]) ?
                                 (~opdata2_i + 1'b1) : opdata2_i;
               end
            end
         end

         BYZERO: begin
            if (annul_i) begin
               w_state_nxt = FREE;
            end else begin
               w_state_nxt  = END;
               w_result_nxt = '0;
               w_ready_nxt  = 1'b1;
            end
         end

         ON: begin
            if (annul_i) begin
               w_state_nxt  = FREE;
               w_result_nxt = '0;
               w_ready_nxt  = 1'b0;
            end else if (r_cnt != c_last_cnt) begin
               if (!w_diff[WIDTH]) begin
                  w_rem_nxt = w_diff[WIDTH-1:0];
                  w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  w_rem_nxt = w_shift[WIDTH-1:0];
                  w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
               end
               w_cnt_nxt = r_cnt + 1'b1;
            end else begin
               w_state_nxt  = END;
               w_result_nxt = {w_rem_fix, w_quo_fix};
               w_ready_nxt  = 1'b1;
            end
         end

         END: begin
            if (!start_i) begin
               w_state_nxt  = FREE;
               w_result_nxt = '0;
               w_ready_nxt  = 1'b0;
            end
         end

         default: w_state_nxt = FREE;
      endcase
   end

endmodule

`default_nettype wire
